// File: rtl/mainbus_pkg.sv
// mainbus_pkg: shared definitions for the multiplexed main-bus initiator.
//   state_e   : burst sequencer states
//   BURST_LEN : beats per burst
//   BUS_W     : width of the multiplexed address/data bus
//   PAGE_MSB/PAGE_LSB : responder page-select field within an address
//   beat_idx  : data-phase state -> beat number (0..3)
//   is_data   : true in DATA1..DATA4
package mainbus_pkg;

  localparam int BURST_LEN = 4;
  localparam int BUS_W     = 16;
  localparam int PAGE_MSB  = 15;
  localparam int PAGE_LSB  = 12;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA1 = 3'd2,
    DATA2 = 3'd3,
    DATA3 = 3'd4,
    DATA4 = 3'd5,
    TURN  = 3'd6
  } state_e;

  function automatic logic [1:0] beat_idx(input state_e s);
    case (s)
      DATA2:   beat_idx = 2'd1;
      DATA3:   beat_idx = 2'd2;
      DATA4:   beat_idx = 2'd3;
      default: beat_idx = 2'd0;
    endcase
  endfunction

  function automatic logic is_data(input state_e s);
    is_data = (s == DATA1) || (s == DATA2) || (s == DATA3) || (s == DATA4);
  endfunction

endpackage

// File: rtl/beat_buffer.sv
// beat_buffer: 4 x 16 storage for one burst, indexed by beat number.
//   clk, rst   : clock, synchronous active-high reset (clears read words only)
//   load       : capture all write words from load_data
//   beat       : current beat number, selects wr_word and the capture slot
//   wr_word    : write word for the current beat
//   capture    : store cap_word into read slot 'beat'
//   rd_data    : all read words, word k at bits [16k+15:16k]
module beat_buffer import mainbus_pkg::*; (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic [BURST_LEN*BUS_W-1:0]   load_data,
  input  logic [1:0]                   beat,
  output logic [BUS_W-1:0]             wr_word,
  input  logic                         capture,
  input  logic [BUS_W-1:0]             cap_word,
  output logic [BURST_LEN*BUS_W-1:0]   rd_data
);

  logic [BUS_W-1:0] wr_mem [BURST_LEN];
  logic [BUS_W-1:0] rd_mem [BURST_LEN];

  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < BURST_LEN; k++) begin
        wr_mem[k] <= load_data[k*BUS_W +: BUS_W];
      end
    end
  end

  // Read words are visible on a port with a defined reset value, so they
  // are cleared; write words are only consumed after a fresh load.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < BURST_LEN; k++) begin
        rd_mem[k] <= '0;
      end
    end else if (capture) begin
      rd_mem[beat] <= cap_word;
    end
  end

  assign wr_word = wr_mem[beat];

  for (genvar k = 0; k < BURST_LEN; k++) begin : g_rd
    assign rd_data[k*BUS_W +: BUS_W] = rd_mem[k];
  end

endmodule

// File: rtl/bus_initiator.sv
// bus_initiator: four-beat burst initiator on a multiplexed 16-bit bus.
//   clk, resetH          : clock, synchronous active-high reset
//   AddrValid, rw        : address strobe, direction (1 = read)
//   AddrData             : tri-state multiplexed address/data bus
//   req_valid/req_ready  : user request handshake
//   req_rw, req_addr     : requested direction and base address
//   wr_data / rd_data    : four beats, word k at bits [16k+15:16k]
//   done                 : one-cycle pulse after the last data beat
// Optional: define INITIATOR_STATS_EN to add rd_count/wr_count outputs.
module bus_initiator import mainbus_pkg::*; #(
  parameter int TURN_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        resetH,
  output logic                        AddrValid,
  output logic                        rw,
  inout  wire  [BUS_W-1:0]            AddrData,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_rw,
  input  logic [BUS_W-1:0]            req_addr,
  input  logic [BURST_LEN*BUS_W-1:0]  wr_data,
  output logic [BURST_LEN*BUS_W-1:0]  rd_data,
  output logic                        done
`ifdef INITIATOR_STATS_EN
  ,
  output logic [15:0]                 rd_count,
  output logic [15:0]                 wr_count
`endif
);

  localparam logic [1:0] TURN_LAST = 2'(TURN_CYCLES - 1);

  state_e           state, state_nxt;
  logic [1:0]       turn_cnt;
  logic [BUS_W-1:0] addr_p1;
  logic             rw_p1;
  logic             done_p1;
  logic             accept;
  logic             bus_en;
  logic [BUS_W-1:0] bus_out;
  logic [BUS_W-1:0] wr_word;

  assign accept = (state == IDLE) && req_valid;

  // Stage p0 -> p1: control state and the request latched at acceptance
  always_ff @(posedge clk) begin
    if (resetH) begin
      state    <= IDLE;
      turn_cnt <= 2'd0;
      done_p1  <= 1'b0;
    end else begin
      state    <= state_nxt;
      turn_cnt <= (state == TURN) ? turn_cnt + 2'd1 : 2'd0;
      done_p1  <= (state == DATA4);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p1 <= req_addr;
      rw_p1   <= req_rw;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = ADDR;
      ADDR:    state_nxt = DATA1;
      DATA1:   state_nxt = DATA2;
      DATA2:   state_nxt = DATA3;
      DATA3:   state_nxt = DATA4;
      DATA4:   state_nxt = rw_p1 ? TURN : IDLE;
      TURN:    if (turn_cnt == TURN_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    AddrValid = 1'b0;
    rw        = 1'b1;
    req_ready = 1'b0;
    bus_en    = 1'b0;
    bus_out   = addr_p1;
    case (state)
      IDLE: req_ready = 1'b1;
      ADDR: begin
        AddrValid = 1'b1;
        rw        = rw_p1;
        bus_en    = 1'b1;
      end
      DATA1, DATA2, DATA3, DATA4: begin
        rw      = rw_p1;
        bus_en  = !rw_p1;
        bus_out = wr_word;
      end
      default: ;
    endcase
  end

  assign AddrData = bus_en ? bus_out : {BUS_W{1'bz}};
  assign done     = done_p1;

  beat_buffer u_beat_buffer (
    .clk       (clk),
    .rst       (resetH),
    .load      (accept),
    .load_data (wr_data),
    .beat      (beat_idx(state)),
    .wr_word   (wr_word),
    .capture   (rw_p1 && is_data(state)),
    .cap_word  (AddrData),
    .rd_data   (rd_data)
  );

`ifdef INITIATOR_STATS_EN
  // rw_p1 still holds the finished burst's direction during the done cycle
  always_ff @(posedge clk) begin
    if (resetH) begin
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else if (done_p1) begin
      if (rw_p1) rd_count <= rd_count + 16'd1;
      else       wr_count <= wr_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bus_initiator.sv
`timescale 1ns/1ps
module tb_bus_initiator;

  localparam int TURN_CYCLES = 1;

  logic        clk = 1'b0;
  logic        resetH;
  logic        AddrValid, rw, req_valid, req_ready, req_rw, done;
  logic [15:0] req_addr;
  logic [63:0] wr_data, rd_data;
  wire  [15:0] AddrData;
`ifdef INITIATOR_STATS_EN
  logic [15:0] rd_count, wr_count;
`endif

  always #5 clk = ~clk;

  bus_initiator #(.TURN_CYCLES(TURN_CYCLES)) dut (
    .clk       (clk),
    .resetH    (resetH),
    .AddrValid (AddrValid),
    .rw        (rw),
    .AddrData  (AddrData),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .done      (done)
`ifdef INITIATOR_STATS_EN
    ,
    .rd_count  (rd_count),
    .wr_count  (wr_count)
`endif
  );

  // Released bus reads as 0
  for (genvar i = 0; i < 16; i++) begin : g_pd
    pulldown (AddrData[i]);
  end

  // Responder: one page, low byte wraps within the page
  logic [15:0] mem [256];
  logic        resp_act = 1'b0;
  logic [1:0]  resp_beat = 2'd0;
  logic [15:0] resp_base = 16'd0;
  logic [7:0]  ridx;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0BAD;
    mem[8'h10] = 16'h1111; mem[8'h11] = 16'h2222;
    mem[8'h12] = 16'h3333; mem[8'h13] = 16'h4444;
    mem[8'hFE] = 16'hCAFE; mem[8'hFF] = 16'hBEEF;
    mem[8'h00] = 16'h1234; mem[8'h01] = 16'h5678;
  end

  always @(posedge clk) begin
    if (resetH) resp_act <= 1'b0;
    else if (AddrValid && rw) begin
      resp_act  <= 1'b1;
      resp_base <= AddrData;
      resp_beat <= 2'd0;
    end else if (resp_act) begin
      resp_beat <= resp_beat + 2'd1;
      if (resp_beat == 2'd3) resp_act <= 1'b0;
    end
  end

  assign ridx     = resp_base[7:0] + {6'd0, resp_beat};
  assign AddrData = (resp_act && rw) ? mem[ridx] : 16'hzzzz;

  // Scoreboard
  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [63:0] data;
    int          gap;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0;
  logic mon_on = 1'b0;
  logic rst_s = 1'b1;
  int   beat = 0;

  always @(posedge clk) rst_s <= resetH;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  initial begin : monitor
    exp_t cur;
    int   turn;
    int   d4;
    turn = 0;
    d4   = -100;
    cur.rw = 1'b0; cur.addr = '0; cur.data = '0; cur.gap = 0;
    wait (mon_on);
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_s) begin
        beat = 0;
        turn = 0;
      end
      if (beat >= 1 && beat <= 4) begin
        chk("beat_bus", AddrData, cur.data[16*(beat-1) +: 16]);
        chk("beat_rw", rw, cur.rw);
        chk("beat_av", AddrValid, 0);
        chk("beat_rdy", req_ready, 0);
        chk("beat_done", done, 0);
        if (beat == 4) d4 = cyc;
        beat++;
      end else if (beat == 5) begin
        chk("done_pulse", done, 1);
        chk("done_rdy", req_ready, !cur.rw);
        chk("done_av", AddrValid, 0);
        chk("done_bus", AddrData, 0);
        if (cur.rw) chk("rd_data_at_done", rd_data, cur.data);
        turn = cur.rw ? TURN_CYCLES - 1 : 0;
        beat = 0;
      end else begin
        chk("idle_done", done, 0);
        if (turn > 0) begin
          chk("turn_rdy", req_ready, 0);
          chk("turn_av", AddrValid, 0);
          chk("turn_bus", AddrData, 0);
          chk("turn_rw", rw, 1);
          turn--;
        end else if (AddrValid === 1'b1) begin
          chk("exp_pending", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            chk("addr_bus", AddrData, cur.addr);
            chk("addr_rw", rw, cur.rw);
            chk("addr_rdy", req_ready, 0);
            if (cur.gap > 0) chk("b2b_gap", cyc - d4, cur.gap);
            beat = 1;
          end
        end else begin
          chk("idle_rdy", req_ready, 1);
          chk("idle_bus", AddrData, 0);
          chk("idle_rw", rw, 1);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge of the ADDR cycle.
  task automatic send(input logic r, input logic [15:0] a, input logic [63:0] wd,
                      input logic [63:0] expd, input int gap);
    exp_t e;
    logic accepted;
    e.rw = r; e.addr = a; e.data = expd; e.gap = gap;
    exp_q.push_back(e);
    req_valid = 1'b1; req_rw = r; req_addr = a; wr_data = wd;
    accepted = 1'b0;
    for (int i = 0; i < 40 && !accepted; i++) begin
      if (req_ready) accepted = 1'b1;
      @(negedge clk);
    end
    chk("accepted", accepted, 1);
  endtask

  task automatic idle_req();
    req_valid = 1'b0;
    req_rw    = 1'b0;
  endtask

  initial begin : stim
    resetH = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_av", AddrValid, 0);
    chk("rst_rw", rw, 1);
    chk("rst_rdy", req_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_bus", AddrData, 0);
`ifdef INITIATOR_STATS_EN
    chk("rst_wr_count", wr_count, 0);
    chk("rst_rd_count", rd_count, 0);
`endif
    resetH = 1'b0;
    mon_on = 1'b1;
    @(negedge clk);

    send(1'b0, 16'h2010, 64'h4444_3333_2222_1111, 64'h4444_3333_2222_1111, 0);
    idle_req();
    repeat (8) @(negedge clk);

    send(1'b1, 16'h2010, '1, 64'h4444_3333_2222_1111, 0);
    idle_req();
    repeat (8) @(negedge clk);
    chk("rd_hold", rd_data, 64'h4444_3333_2222_1111);

    // write then read with req_valid held throughout
    send(1'b0, 16'h3000, 64'h8888_7777_6666_5555, 64'h8888_7777_6666_5555, 0);
    send(1'b1, 16'h20FE, '1, 64'h5678_1234_BEEF_CAFE, 2);
    idle_req();
    repeat (10) @(negedge clk);

    send(1'b0, 16'h4000, 64'hDDDD_CCCC_BBBB_AAAA, 64'hDDDD_CCCC_BBBB_AAAA, 0);
    idle_req();
    repeat (8) @(negedge clk);
    chk("rd_kept_by_write", rd_data, 64'h5678_1234_BEEF_CAFE);
`ifdef INITIATOR_STATS_EN
    chk("wr_count", wr_count, 3);
    chk("rd_count", rd_count, 2);
`endif

    // reset during DATA2 of a write
    send(1'b0, 16'h2010, 64'h4444_3333_2222_1111, 64'h4444_3333_2222_1111, 0);
    idle_req();
    @(negedge clk);
    @(negedge clk);
    resetH = 1'b1;
    @(negedge clk);
    resetH = 1'b0;
    chk("abort_av", AddrValid, 0);
    chk("abort_bus", AddrData, 0);
    chk("abort_rdy", req_ready, 1);
    chk("abort_rd_data", rd_data, 0);
`ifdef INITIATOR_STATS_EN
    chk("abort_wr_count", wr_count, 0);
    chk("abort_rd_count", rd_count, 0);
`endif
    repeat (10) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    chk("monitor_idle", beat, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
